// File: rtl/ie_defs.sv
// Shared definitions for the boot-time program loader.
package ie_defs;

    typedef enum logic [3:0] {
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_PC_LO,
        S_PC_HI,
        S_RELEASE,
        S_RUN
    } ldr_state_t;

    // Bytes ahead of the data payload: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI.
    localparam int LDR_HDR_BYTES = 4;

    // States in which the loader takes a byte from the stream.
    function automatic logic ldr_accepts(ldr_state_t s);
        return (s != S_RELEASE) && (s != S_RUN);
    endfunction

endpackage

// File: rtl/prg_loader.sv
// Boot-time program loader: parses a framed byte stream into RAM while the
// CPU is held in reset, then latches the entry PC and releases the CPU.
// Also owns the RAM bus mux between the loader and the CPU.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   S_ADDR_LO  | waiting for load address, low byte
//   S_ADDR_HI  | waiting for load address, high byte
//   S_LEN_LO   | waiting for payload length, low byte
//   S_LEN_HI   | waiting for payload length, high byte
//   S_DATA     | streaming payload bytes into RAM
//   S_PC_LO    | waiting for entry PC, low byte
//   S_PC_HI    | waiting for entry PC, high byte
//   S_RELEASE  | counting down before CPU reset release
//   S_RUN      | CPU owns the bus; loader idle until load_req
module prg_loader
    import ie_defs::*;
#(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] DEFAULT_PC    = ADDR_W'(16'h8000),
    parameter int                RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_req,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] pc_reset,
    output logic              loading,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [7:0]        cpu_data_out,
    input  logic              cpu_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_wr,
    output logic              mem_write_en
);

    ldr_state_t        state;
    ldr_state_t        state_nxt;
    logic              in_ready_q;
    logic              cpu_rst_q;
    logic              hs;

    logic [7:0]        addr_lo_q;
    logic [7:0]        len_lo_q;
    logic [7:0]        pc_lo_q;
    logic [15:0]       count_q;
    logic [3:0]        rel_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] pc_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    // in_ready is registered, so a transfer never depends combinationally on in_valid.
    assign hs       = in_valid && in_ready_q;
    assign in_ready = in_ready_q;
    assign cpu_rst  = cpu_rst_q;
    assign pc_reset = pc_q;

    // State register plus registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_ADDR_LO;
            in_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= ldr_accepts(state_nxt);
            cpu_rst_q  <= (state_nxt == S_RUN);
        end
    end

    // Next-state logic: header/PC states step on one handshake each.
    always_comb begin
        state_nxt = state;
        case (state)
            S_ADDR_LO: if (hs) state_nxt = S_ADDR_HI;
            S_ADDR_HI: if (hs) state_nxt = S_LEN_LO;
            S_LEN_LO:  if (hs) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (hs) begin
                    state_nxt = ({in_data, len_lo_q} == 16'h0000) ? S_PC_LO : S_DATA;
                end
            end
            S_DATA:    if (hs && (count_q == 16'd1)) state_nxt = S_PC_LO;
            S_PC_LO:   if (hs) state_nxt = S_PC_HI;
            S_PC_HI:   if (hs) state_nxt = S_RELEASE;
            S_RELEASE: if (rel_cnt_q <= 4'd1) state_nxt = S_RUN;
            S_RUN:     if (load_req) state_nxt = S_ADDR_LO;
            default:   state_nxt = S_ADDR_LO;
        endcase
    end

    // Frame datapath: header capture, write pointer/count, PC latch, release timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_lo_q <= 8'h00;
            len_lo_q  <= 8'h00;
            pc_lo_q   <= 8'h00;
            count_q   <= 16'h0000;
            rel_cnt_q <= 4'd0;
            wr_ptr_q  <= '0;
            pc_q      <= DEFAULT_PC;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_ADDR_LO: if (hs) addr_lo_q <= in_data;
                S_ADDR_HI: if (hs) wr_ptr_q <= ADDR_W'({in_data, addr_lo_q});
                S_LEN_LO:  if (hs) len_lo_q <= in_data;
                S_LEN_HI:  if (hs) count_q <= {in_data, len_lo_q};
                S_DATA: begin
                    if (hs) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_ptr_q;
                        wr_data_q <= in_data;
                        wr_ptr_q  <= wr_ptr_q + 1'b1;
                        count_q   <= count_q - 16'd1;
                    end
                end
                S_PC_LO:   if (hs) pc_lo_q <= in_data;
                S_PC_HI: begin
                    if (hs) begin
                        pc_q      <= ADDR_W'({in_data, pc_lo_q});
                        rel_cnt_q <= 4'(RELEASE_DELAY);
                    end
                end
                S_RELEASE: if (rel_cnt_q != 4'd0) rel_cnt_q <= rel_cnt_q - 4'd1;
                default: ;
            endcase
        end
    end

    // Bus mux: the CPU drives RAM only in S_RUN; otherwise the loader's registered write.
    always_comb begin
        loading      = (state != S_RUN);
        mem_addr     = wr_addr_q;
        mem_data_wr  = wr_data_q;
        mem_write_en = wr_en_q;
        if (state == S_RUN) begin
            mem_addr     = cpu_mem_addr;
            mem_data_wr  = cpu_data_out;
            mem_write_en = cpu_write_en;
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader with a behavioural RAM image model.
module tb_prg_loader;
    import ie_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        load_req = 1'b0;
    logic        cpu_rst;
    logic [15:0] pc_reset;
    logic        loading;
    logic [15:0] cpu_mem_addr = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_wr;
    logic        mem_write_en;

    prg_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .load_req     (load_req),
        .cpu_rst      (cpu_rst),
        .pc_reset     (pc_reset),
        .loading      (loading),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .mem_addr     (mem_addr),
        .mem_data_wr  (mem_data_wr),
        .mem_write_en (mem_write_en)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:65535];
    logic [7:0] exp_ram [0:65535];
    int         wr_pulses = 0;
    int         errors = 0;
    int         checks = 0;

    // Bench-side RAM; loader write pulses are counted separately from CPU writes.
    always @(posedge clk) begin
        if (mem_write_en) begin
            ram[mem_addr] <= mem_data_wr;
            if (loading) wr_pulses++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, bit gaps);
        int n = 0;
        if (gaps) begin
            in_valid = 1'b0;
            for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_data  = $urandom_range(255, 0);
    endtask

    // Sends a full frame, updates the image model and checks release, PC and RAM.
    task automatic send_frame(string tag, logic [15:0] addr, logic [7:0] data[$],
                              logic [15:0] pc, bit gaps);
        int base = wr_pulses;
        int len  = data.size();
        int n    = 0;
        logic [15:0] a;
        send_byte(addr[7:0], gaps);
        send_byte(addr[15:8], gaps);
        send_byte(8'(len), gaps);
        send_byte(8'(len >> 8), gaps);
        for (int i = 0; i < len; i++) begin
            send_byte(data[i], gaps);
            a = addr + 16'(i);
            exp_ram[a] = data[i];
        end
        send_byte(pc[7:0], gaps);
        send_byte(pc[15:8], gaps);
        chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        chk({tag, "_cpu_held"}, 32'(cpu_rst), 32'd0);
        while (!cpu_rst && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_release_delay"}, n, 32'd2);
        chk({tag, "_pc"}, 32'(pc_reset), 32'(pc));
        chk({tag, "_loading"}, 32'(loading), 32'd0);
        chk({tag, "_pulses"}, wr_pulses - base, len);
        for (int i = -1; i <= len; i++) begin
            a = addr + 16'(i);
            chk({tag, "_ram"}, {16'(a), ram[a]}, {16'(a), exp_ram[a]});
        end
    endtask

    task automatic reload();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    initial begin
        logic [7:0] d[$];
        logic [15:0] ra;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'h00;
            exp_ram[i] = 8'h00;
        end

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("rst_loading", 32'(loading), 32'd1);
        chk("rst_pc", 32'(pc_reset), 32'h8000);
        chk("rst_wen", 32'(mem_write_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_data_wr), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic frame, then CPU fetch passes through
        d = '{8'hA9, 8'h05, 8'h00};
        send_frame("basic", 16'h0200, d, 16'h0200, 1'b0);
        cpu_mem_addr = 16'h0200;
        #1;
        chk("fetch_addr", 32'(mem_addr), 32'h0200);
        chk("fetch_wen", 32'(mem_write_en), 32'd0);

        // Write pointer wraps past 0xFFFF
        reload();
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame("wrap", 16'hFFFE, d, 16'h0400, 1'b0);

        // Empty payload
        reload();
        d = {};
        send_frame("len0", 16'h5000, d, 16'hC000, 1'b0);

        // 16-byte frames, gap-free then with random in_valid gaps
        ra = 16'($urandom_range(65535, 0));
        reload();
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(8'($urandom_range(255, 0)));
        send_frame("nogap", ra, d, 16'(ra + 16'h0100), 1'b0);
        reload();
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(8'($urandom_range(255, 0)));
        send_frame("gap", ra ^ 16'h8000, d, 16'h0300, 1'b1);

        // CPU write passes in S_RUN; load_req blocks it and reloads
        cpu_mem_addr = 16'h0010;
        cpu_data_out = 8'h5A;
        cpu_write_en = 1'b1;
        #1;
        chk("cpu_wr_en", 32'(mem_write_en), 32'd1);
        chk("cpu_wr_addr", 32'(mem_addr), 32'h0010);
        chk("cpu_wr_data", 32'(mem_data_wr), 32'h5A);
        tick();
        exp_ram[16'h0010] = 8'h5A;
        cpu_write_en = 1'b0;
        reload();
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("reload_loading", 32'(loading), 32'd1);
        chk("reload_pc_held", 32'(pc_reset), 32'h0300);
        cpu_data_out = 8'hEE;
        cpu_write_en = 1'b1;
        #1;
        chk("blocked_wen", 32'(mem_write_en), 32'd0);
        tick();
        cpu_write_en = 1'b0;
        chk("blocked_ram", 32'(ram[16'h0010]), 32'h5A);
        d = '{8'h01, 8'h02};
        send_frame("reload", 16'h0700, d, 16'h1234, 1'b1);

        // Reset mid-frame keeps the partial image and restarts at ADDR_LO
        reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b0);
        exp_ram[16'h3000] = 8'hD0;
        exp_ram[16'h3001] = 8'hD1;
        rst = 1'b0;
        tick();
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("abort_state", 32'(dut.state), 32'(S_ADDR_LO));
        chk("abort_pc", 32'(pc_reset), 32'h8000);
        chk("abort_loading", 32'(loading), 32'd1);
        chk("abort_wen", 32'(mem_write_en), 32'd0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++)
            chk("abort_ram", 32'(ram[16'h3000 + 16'(i)]), 32'(exp_ram[16'h3000 + 16'(i)]));
        d = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        send_frame("after_abort", 16'h3000, d, 16'h3000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Boot-time program loader upstream of cpu_6502.
- Accepts a framed byte stream and writes the program image into the shared 64 KiB generic_ram while holding the CPU in reset.
- Once loaded, latches the entry PC onto pc_reset and releases the CPU.
- Owns the memory-bus mux between itself and the CPU. It replaces the bench-side load tasks and the rst-driven address/data/write muxing.

Parameters:
- ADDR_W, 16: memory address width.
- DEFAULT_PC, 16'h8000: pc_reset value out of reset.
- RELEASE_DELAY, 2: cycles between frame completion and CPU reset release, range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready at posedge.
- load_req  in  1  level; re-enter loading from RUN.
- cpu_rst  out  1  to cpu_6502 rst, active-low.
- pc_reset  out  ADDR_W  entry PC to cpu_6502.
- loading  out  1  high in any state other than RUN.
- cpu_mem_addr  in  ADDR_W  CPU bus address.
- cpu_data_out  in  8  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- mem_addr  out  ADDR_W  to RAM.
- mem_data_wr  out  8  to RAM.
- mem_write_en  out  1  to RAM.

Behaviour:
- Frame format, little-endian: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN data bytes, then PC_LO, PC_HI.
- FSM states: S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_PC_LO, S_PC_HI, S_RELEASE, S_RUN.
- Each header/PC state advances on one handshake.
- S_LEN_HI with {hi,lo}==0 goes directly to S_PC_LO.
- S_DATA: each handshake issues a write and decrements the remaining count. The handshake taking the count from 1 to 0 moves to S_PC_LO.
- S_PC_HI handshake: latch pc_reset = {hi,lo}, load release counter = RELEASE_DELAY, go to S_RELEASE.
- S_RELEASE: counter decrements each cycle. The cycle it reaches 0, go to S_RUN.
- S_RUN with load_req=1: go to S_ADDR_LO next cycle. pc_reset holds its old value until the next PC_HI.
- in_ready = 1 in S_ADDR_LO..S_PC_HI; 0 in S_RELEASE and S_RUN. in_ready is a registered-state decode with no combinational path from in_valid.
- Writes are registered with 1-cycle latency. A byte accepted at edge k drives mem_addr = wr_ptr, mem_data_wr = byte, mem_write_en = 1 during cycle k+1, i.e. written to RAM at edge k+1.
- mem_write_en = 0 in every loader cycle without a pending write.
- wr_ptr starts at {ADDR_HI, ADDR_LO} and increments after each write, wrapping 16'hFFFF -> 16'h0000. Length 16'h0000 means no data; a full 64 KiB image is impossible by design.
- cpu_rst is a registered output: 1 only while the state is S_RUN.
  - Deasserts (goes 1) on the cycle the state becomes S_RUN.
  - Reasserts (goes 0) on the cycle after load_req is sampled in S_RUN.
- Bus mux: state == S_RUN passes cpu_mem_addr, cpu_data_out, cpu_write_en combinationally. Otherwise the loader's registered write signals drive the bus.
  - The final data write's cycle falls inside S_PC_LO or later, never S_RUN, so no write is lost.
- load_req is ignored outside S_RUN.
- Reset values: state S_ADDR_LO, cpu_rst 0, pc_reset DEFAULT_PC, loading 1, in_ready 0 (ready 1 from the first post-reset cycle), mem_write_en 0, mem_addr 0, mem_data_wr 0, wr_ptr 0, count 0.
- Reset mid-frame aborts the frame. A partial image stays in RAM; the next frame starts at ADDR_LO.
- in_valid gaps of any length in any state are tolerated; state is held.

Decomposition:
- Package ie_defs gets the state enum typedef ldr_state_t and the frame-header byte count constant LDR_HDR_BYTES = 4.
- No sub-module. The bus mux is inline combinational logic in prg_loader.

Test Plan:
- Frame addr 16'h0200, len 3, data A9 05 00, PC 16'h0200 -> RAM[0200..0202] = A9,05,00; pc_reset = 16'h0200; cpu_rst rises exactly 2 cycles after the PC_HI handshake; CPU then fetches from 16'h0200.
- Frame addr 16'hFFFE, len 4, data 11 22 33 44 -> RAM[FFFE] = 11, RAM[FFFF] = 22, RAM[0000] = 33, RAM[0001] = 44.
- len 0, PC 16'hC000 -> no mem_write_en pulses; pc_reset = 16'hC000; CPU released.
- Random in_valid gaps (about 50% duty) on a 16-byte frame -> RAM contents identical to the gap-free run; exactly 16 write pulses.
- In S_RUN, CPU write to 16'h0010 passes through; then load_req = 1 -> cpu_rst = 0 next cycle; CPU writes are blocked; a reload frame completes and the CPU is re-released with the new PC.
- rst = 0 asserted after 2 of 5 data bytes -> cpu_rst = 0, state S_ADDR_LO, pc_reset = 16'h8000; a subsequent full frame loads correctly.
